// File: rtl/tpu_tile_sequencer_if.sv
// tpu_tile_sequencer_if: host, weight FIFO, UB and result SRAM signals of the tile sequencer.
// Optional perf counter outputs are present when TPU_SEQ_PERF_EN is defined.
interface tpu_tile_sequencer_if #(
    parameter int ADDRESSSIZE = 10,
    parameter int TILE_BW     = 8
);
    logic                   start;
    logic [TILE_BW-1:0]     num_tiles;
    logic [ADDRESSSIZE-1:0] ub_base;
    logic [ADDRESSSIZE-1:0] res_base;
    logic                   fifo_empty;
    logic                   busy;
    logic                   done;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic                   ub_read_en;
    logic [ADDRESSSIZE-1:0] ub_read_address;
    logic                   res_write_enable;
    logic [ADDRESSSIZE-1:0] res_address;
    logic [TILE_BW-1:0]     tile_index;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0]            perf_busy_cycles;
    logic [31:0]            perf_stall_cycles;
    modport master (
        input  start, num_tiles, ub_base, res_base, fifo_empty,
        output busy, done, fifo_read_enable, we_rl, ub_read_en, ub_read_address,
               res_write_enable, res_address, tile_index, perf_busy_cycles, perf_stall_cycles
    );
    modport slave (
        output start, num_tiles, ub_base, res_base, fifo_empty,
        input  busy, done, fifo_read_enable, we_rl, ub_read_en, ub_read_address,
               res_write_enable, res_address, tile_index, perf_busy_cycles, perf_stall_cycles
    );
`else
    modport master (
        input  start, num_tiles, ub_base, res_base, fifo_empty,
        output busy, done, fifo_read_enable, we_rl, ub_read_en, ub_read_address,
               res_write_enable, res_address, tile_index
    );
    modport slave (
        output start, num_tiles, ub_base, res_base, fifo_empty,
        input  busy, done, fifo_read_enable, we_rl, ub_read_en, ub_read_address,
               res_write_enable, res_address, tile_index
    );
`endif
endinterface

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer: runs N tiles of weight load, UB row streaming and delayed result writes.
// Define TPU_SEQ_PERF_EN to add the perf_busy_cycles / perf_stall_cycles counters.
module tpu_tile_sequencer #(
    parameter int MATRIX_SIZE        = 16,
    parameter int ADDRESSSIZE        = 10,
    parameter int TILE_BW            = 8,
    parameter int WEIGHT_PIPE_STAGES = 1,
    parameter int RESULT_LAT         = 35
) (
    input logic clk,
    input logic rstn,
    tpu_tile_sequencer_if.master bus
);
    localparam int DRAIN_N = RESULT_LAT - MATRIX_SIZE;
    localparam int CW      = $clog2(RESULT_LAT + WEIGHT_PIPE_STAGES + 2);

    typedef enum logic [2:0] {IDLE, WLOAD, WPIPE, WRELOAD, STREAM, DRAIN, WRITE, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [TILE_BW-1:0]     nt;
    logic [TILE_BW-1:0]     tile;
    logic [ADDRESSSIZE-1:0] ub_ptr;
    logic [ADDRESSSIZE-1:0] res_ptr;
    logic                   busy;
    logic                   done;
    logic                   we_rl;
    logic                   ub_en;
    logic                   res_we;
    logic                   more_tiles;

    assign more_tiles           = ({1'b0, tile} + (TILE_BW+1)'(1)) < {1'b0, nt};
    assign bus.fifo_read_enable = (state == WLOAD) && !bus.fifo_empty;
    assign bus.busy             = busy;
    assign bus.done             = done;
    assign bus.we_rl            = we_rl;
    assign bus.ub_read_en       = ub_en;
    assign bus.ub_read_address  = ub_ptr;
    assign bus.res_write_enable = res_we;
    assign bus.res_address      = res_ptr;
    assign bus.tile_index       = tile;

    // Tile FSM; row pointers advance one row per strobe cycle so they run contiguously across tiles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            nt      <= '0;
            tile    <= '0;
            ub_ptr  <= '0;
            res_ptr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we_rl   <= 1'b0;
            ub_en   <= 1'b0;
            res_we  <= 1'b0;
        end else begin
            done  <= 1'b0;
            we_rl <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    busy <= 1'b1;
                    if (bus.num_tiles == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= WLOAD;
                        nt      <= bus.num_tiles;
                        tile    <= '0;
                        ub_ptr  <= bus.ub_base;
                        res_ptr <= bus.res_base;
                    end
                end
                WLOAD: if (!bus.fifo_empty) begin
                    cnt <= '0;
                    if (WEIGHT_PIPE_STAGES == 0) begin
                        state <= WRELOAD;
                        we_rl <= 1'b1;
                    end else begin
                        state <= WPIPE;
                    end
                end
                WPIPE: if (cnt == CW'(WEIGHT_PIPE_STAGES - 1)) begin
                    state <= WRELOAD;
                    we_rl <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                WRELOAD: begin
                    state <= STREAM;
                    ub_en <= 1'b1;
                end
                STREAM: begin
                    ub_ptr <= ub_ptr + ADDRESSSIZE'(1);
                    if (cnt == CW'(MATRIX_SIZE - 1)) begin
                        cnt   <= '0;
                        ub_en <= 1'b0;
                        if (DRAIN_N == 0) begin
                            state  <= WRITE;
                            res_we <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: if (cnt == CW'(DRAIN_N - 1)) begin
                    cnt    <= '0;
                    state  <= WRITE;
                    res_we <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                WRITE: begin
                    res_ptr <= res_ptr + ADDRESSSIZE'(1);
                    if (cnt == CW'(MATRIX_SIZE - 1)) begin
                        cnt    <= '0;
                        res_we <= 1'b0;
                        if (more_tiles) begin
                            tile  <= tile + TILE_BW'(1);
                            state <= WLOAD;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TPU_SEQ_PERF_EN
    // Saturating job counters, cleared by an accepted start and held while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.perf_busy_cycles  <= '0;
            bus.perf_stall_cycles <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                bus.perf_busy_cycles  <= '0;
                bus.perf_stall_cycles <= '0;
            end
        end else begin
            if (bus.perf_busy_cycles != '1)
                bus.perf_busy_cycles <= bus.perf_busy_cycles + 32'd1;
            if (state == WLOAD && bus.fifo_empty && bus.perf_stall_cycles != '1)
                bus.perf_stall_cycles <= bus.perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb_tpu_tile_sequencer: directed cycle-by-cycle checks of tile timing, addresses, reset and restart.
module tb_tpu_tile_sequencer;
    localparam int MS  = 4;
    localparam int AW  = 10;
    localparam int TW  = 8;
    localparam int WPS = 1;
    localparam int RL  = 11;
    localparam int TL  = 2 + WPS + RL + MS;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    tpu_tile_sequencer_if #(.ADDRESSSIZE(AW), .TILE_BW(TW)) bus ();

    tpu_tile_sequencer #(
        .MATRIX_SIZE(MS), .ADDRESSSIZE(AW), .TILE_BW(TW),
        .WEIGHT_PIPE_STAGES(WPS), .RESULT_LAT(RL)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.busy, bus.done, bus.fifo_read_enable, bus.we_rl, bus.ub_read_en, bus.res_write_enable};
    endfunction

    // Runs one job from cycle 0 (start) to one cycle past done, checking every cycle.
    // s: FIFO empty cycles at first WLOAD; rc: cycle with a spurious start (-1 for none).
    task automatic run_job(input int job, input int nt, input int ub, input int res, input int s, input int rc);
        int d, p, t, r;
        logic [5:0] e;
        logic [AW-1:0] ea;
        d = (nt == 0) ? 1 : 1 + s + TL * nt;
        bus.start = 1'b1;
        bus.num_tiles = TW'(nt);
        bus.ub_base = AW'(ub);
        bus.res_base = AW'(res);
        bus.fifo_empty = 1'b0;
        for (int c = 0; c <= d + 1; c++) begin
            if (c > 0) begin
                bus.start = (c == rc);
                bus.num_tiles = TW'((c == rc) ? nt + 2 : nt);
                bus.fifo_empty = (c <= s);
            end
            @(negedge clk);
            e = '0;
            ea = '0;
            t = 0;
            if (c == d) begin
                e = 6'b110000;
            end else if (c > 0 && c < d) begin
                e[5] = 1'b1;
                p = c - 1 - s;
                if (p >= 0) begin
                    t = p / TL;
                    r = p % TL;
                    e[3] = (r == 0);
                    e[2] = (r == 1 + WPS);
                    e[1] = (r >= 2 + WPS) && (r < 2 + WPS + MS);
                    e[0] = (r >= 2 + WPS + RL) && (r < 2 + WPS + RL + MS);
                    if (e[1]) ea = AW'(ub + t * MS + r - (2 + WPS));
                    if (e[0]) ea = AW'(res + t * MS + r - (2 + WPS + RL));
                end
                chk($sformatf("j%0d c%0d tile_index", job, c), 32'(bus.tile_index), 32'(t));
            end
            chk($sformatf("j%0d c%0d strobes", job, c), 32'(strobes()), 32'(e));
            if (e[1]) chk($sformatf("j%0d c%0d ub_addr", job, c), 32'(bus.ub_read_address), 32'(ea));
            if (e[0]) chk($sformatf("j%0d c%0d res_addr", job, c), 32'(bus.res_address), 32'(ea));
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
`ifdef TPU_SEQ_PERF_EN
        chk($sformatf("j%0d perf_busy", job), bus.perf_busy_cycles, 32'(d));
        chk($sformatf("j%0d perf_stall", job), bus.perf_stall_cycles, 32'(s));
`endif
    endtask

    // Starts a job and asserts reset in the STREAM cycle with k=2.
    task automatic reset_mid_job();
        logic seen;
        bus.start = 1'b1;
        bus.num_tiles = 8'd1;
        bus.ub_base = 10'h010;
        bus.res_base = 10'h020;
        bus.fifo_empty = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        chk("rst pre ub_en", 32'(bus.ub_read_en), 32'd1);
        chk("rst pre ub_addr", 32'(bus.ub_read_address), 32'h012);
        #1 rstn = 1'b0;
        #1;
        chk("rst strobes", 32'(strobes()), 32'd0);
        chk("rst addrs", 32'({bus.ub_read_address, bus.res_address}), 32'd0);
        chk("rst tile", 32'(bus.tile_index), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            seen = seen | bus.done | bus.busy;
            @(posedge clk);
            #1;
        end
        chk("no activity after reset", 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.num_tiles = '0;
        bus.ub_base = '0;
        bus.res_base = '0;
        bus.fifo_empty = 1'b1;
        #2;
        chk("reset strobes", 32'(strobes()), 32'd0);
        chk("reset addrs", 32'({bus.ub_read_address, bus.res_address}), 32'd0);
        chk("reset tile", 32'(bus.tile_index), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        run_job(1, 1, 'h010, 'h020, 0, -1);
        run_job(2, 3, 'h010, 'h020, 0, -1);
        run_job(3, 1, 'h010, 'h020, 5, -1);
        run_job(4, 1, 'h3FE, 'h020, 0, -1);
        reset_mid_job();
        run_job(5, 1, 'h010, 'h020, 0, -1);
        run_job(6, 0, 'h010, 'h020, 0, -1);
        run_job(7, 2, 'h100, 'h200, 0, 10);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
- Parametrised control sequencer for the systolic TPU datapath. It replaces the hard-wired 16-cycle state counter and the 5-bit result-timing counter.
- Runs a programmable number of tiles back to back. For each tile it pops one weight set from the weight FIFO and pulses weight reload. It then streams MATRIX_SIZE unified-buffer rows and writes MATRIX_SIZE result rows after a configurable pipeline latency.
- Sits between the host start/done interface and the unified buffer, weight FIFO, systolic array and result SRAM.

Parameters:
- MATRIX_SIZE, 16, rows streamed per tile and result rows written per tile (>=2).
- ADDRESSSIZE, 10, width of UB and result SRAM addresses.
- TILE_BW, 8, width of the tile-count input.
- WEIGHT_PIPE_STAGES, 1, register stages between FIFO output and array weight input (>=0).
- RESULT_LAT, 35, cycles from first UB read to first result write (must be >= MATRIX_SIZE).

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  begin a job; sampled only in IDLE
- num_tiles  input  TILE_BW  tiles in the job; sampled with start
- ub_base  input  ADDRESSSIZE  UB address of tile 0 row 0; sampled with start
- res_base  input  ADDRESSSIZE  result address of tile 0 row 0; sampled with start
- fifo_empty  input  1  weight FIFO has no entry
- busy  output  1  job in progress
- done  output  1  one-cycle job-complete pulse
- fifo_read_enable  output  1  pop one weight set
- we_rl  output  1  systolic weight reload pulse
- ub_read_en  output  1  UB row read valid
- ub_read_address  output  ADDRESSSIZE  UB row address
- res_write_enable  output  1  result SRAM write strobe
- res_address  output  ADDRESSSIZE  result SRAM row address
- tile_index  output  TILE_BW  current tile number

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rstn).
- Reset, including mid-job: state=IDLE, all counters 0, all outputs 0. The job is discarded and no done pulse is produced.
- States: IDLE, WLOAD, WPIPE, WRELOAD, STREAM, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 with num_tiles>0: latch num_tiles, ub_base and res_base; tile_index=0; go to WLOAD.
  - start=1 with num_tiles=0: go directly to DONE.
  - start is ignored in every other state.
- WLOAD:
  - fifo_read_enable = !fifo_empty. This is the only combinational input-to-output path.
  - Stays in WLOAD while fifo_empty=1 (stall; no other outputs asserted).
  - On the pop cycle, go to WPIPE, or to WRELOAD if WEIGHT_PIPE_STAGES=0.
- WPIPE: exactly WEIGHT_PIPE_STAGES cycles, then WRELOAD.
- WRELOAD: we_rl=1 for exactly one cycle, then STREAM.
- STREAM:
  - MATRIX_SIZE cycles, row counter k=0..MATRIX_SIZE-1.
  - ub_read_en=1.
  - ub_read_address = ub_base + tile_index*MATRIX_SIZE + k, modulo 2^ADDRESSSIZE.
- DRAIN: RESULT_LAT-MATRIX_SIZE cycles with all strobes low. If that count is 0, STREAM goes straight to WRITE.
- WRITE:
  - MATRIX_SIZE cycles, res_write_enable=1.
  - res_address = res_base + tile_index*MATRIX_SIZE + k, modulo 2^ADDRESSSIZE.
  - The first write occurs exactly RESULT_LAT cycles after the first STREAM cycle.
- After WRITE: if tile_index+1 < latched num_tiles, increment tile_index and go to WLOAD; otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE, including DONE.
- Tiles do not overlap: the next weight pop happens only after the previous tile's last write.
- Except fifo_read_enable, all outputs are registered or decoded from registered state and counters.
- Address arithmetic is done at ADDRESSSIZE+TILE_BW width and truncated.

Optional Feature:
- Macro: TPU_SEQ_PERF_EN.
- Defined: adds outputs perf_busy_cycles [31:0] and perf_stall_cycles [31:0].
  - Both clear on an accepted start (cleared to 0 in the cycle after start is sampled).
  - perf_busy_cycles increments each busy cycle.
  - perf_stall_cycles increments each WLOAD cycle with fifo_empty=1.
  - Both saturate at 2^32-1, hold after done, and reset to 0.
- Undefined: the ports and the counters are absent. Behaviour is otherwise identical.

Test Plan (MATRIX_SIZE=4, RESULT_LAT=11, WEIGHT_PIPE_STAGES=1, ADDRESSSIZE=10):
- start at cycle 0 with num_tiles=1, ub_base=0x010, res_base=0x020, FIFO non-empty -> expected:
  - fifo_read_enable at cycle 1.
  - we_rl at cycle 3.
  - ub_read_en cycles 4-7 with addresses 0x010-0x013.
  - res_write_enable cycles 15-18 with addresses 0x020-0x023.
  - done at cycle 19; busy high cycles 1-19, low at cycle 20.
- num_tiles=3, FIFO non-empty -> three pops, 12 UB reads over 0x010-0x01B, 12 writes over 0x020-0x02B, tile_index 0/1/2, one done pulse.
- fifo_empty=1 for 5 cycles after entering WLOAD -> no strobes during the stall; all later events shift by 5 cycles. With TPU_SEQ_PERF_EN: perf_stall_cycles=5, perf_busy_cycles=24.
- ub_base=0x3FE, num_tiles=1 -> UB addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
- rstn low during the STREAM cycle with k=2 -> all outputs 0 immediately, no done pulse; a new start afterwards runs a clean job. num_tiles=0 -> done at cycle 1, no strobes.
- start pulsed again mid-job -> ignored; the job completes unchanged with a single done pulse.
